// File: rtl/accumulator_drain_scheduler.sv
// Drains accumulator rows into the unified buffer through a 2-entry FIFO,
// always yielding the shared accumulator read port to the MAC accumulate path.
module accumulator_drain_scheduler #(
    parameter int unsigned MUL_SIZE = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              drain_start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] row_cnt_i,
    input  logic [ADDR_W-1:0] ub_base_addr_i,
    input  logic              mac_rd_req_i,
    input  logic [ADDR_W-1:0] mac_rd_addr_i,
    output logic              mac_rd_grant_o,
    output logic              accum_rd_en_o,
    output logic [ADDR_W-1:0] accum_rd_addr_o,
    input  logic [DATA_W-1:0] accum_rd_data_i,
    output logic              ub_wr_valid_o,
    input  logic              ub_wr_ready_i,
    output logic [ADDR_W-1:0] ub_wr_addr_o,
    output logic [DATA_W-1:0] ub_wr_data_o,
    output logic              busy_o,
    output logic              drain_done_o
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned LANE_W = DATA_W / MUL_SIZE;

    // One accumulator row viewed as MUL_SIZE lanes of the systolic array.
    typedef logic [MUL_SIZE-1:0][LANE_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] ub_base_q;
    logic [CNT_W-1:0]  rows_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  written_q;
    row_t              fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              tag_q;
    logic              done_q;

    logic              mac_gnt;
    logic              drain_rd;
    logic              push;
    logic              pop;
    logic              fifo_valid;
    logic [2:0]        pending;
    logic [ADDR_W-1:0] drain_addr;

    assign mac_gnt    = mac_rd_req_i & ~rst_i;
    assign fifo_valid = (fifo_cnt != 2'd0);
    assign pop        = fifo_valid & ub_wr_ready_i;
    assign push       = tag_q;
    // A pop this cycle frees a slot, which keeps the sustained rate at one row per cycle.
    assign pending    = 3'(fifo_cnt) + 3'(tag_q) - 3'(pop);
    assign drain_addr = ADDR_W'(base_q + issued_q[ADDR_W-1:0]);
    assign drain_rd   = (state == ISSUE) & ~rst_i & ~mac_rd_req_i
                      & (issued_q < rows_q) & (pending < 3'd2);

    assign mac_rd_grant_o = mac_gnt;
    assign accum_rd_en_o  = mac_gnt | drain_rd;
    assign ub_wr_valid_o  = fifo_valid;
    assign ub_wr_data_o   = fifo_valid ? fifo_mem[rd_ptr] : '0;
    assign ub_wr_addr_o   = fifo_valid ? ADDR_W'(ub_base_q + written_q[ADDR_W-1:0]) : '0;
    assign busy_o         = (state != IDLE);
    assign drain_done_o   = done_q;

    always_comb begin
        accum_rd_addr_o = '0;
        if (mac_gnt) begin
            accum_rd_addr_o = mac_rd_addr_i;
        end else if (drain_rd) begin
            accum_rd_addr_o = drain_addr;
        end
    end

    // Row storage carries no reset; the output mux hides stale contents when empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= row_t'(accum_rd_data_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            base_q    <= '0;
            ub_base_q <= '0;
            rows_q    <= '0;
            issued_q  <= '0;
            written_q <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= '0;
            tag_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tag_q  <= drain_rd;
            done_q <= 1'b0;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                written_q <= written_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drain_rd) begin
                issued_q <= issued_q + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (drain_start_i) begin
                        base_q    <= base_addr_i;
                        ub_base_q <= ub_base_addr_i;
                        rows_q    <= CNT_W'(row_cnt_i);
                        issued_q  <= '0;
                        written_q <= '0;
                        if (row_cnt_i == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (drain_rd && ((issued_q + CNT_W'(1)) == rows_q)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Completion is taken on the cycle of the final transfer.
                    if ((written_q + CNT_W'(pop)) == rows_q) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_drain_scheduler.sv
// Directed bench for accumulator_drain_scheduler: per-cycle monitor records reads,
// writes and done pulses relative to the start cycle; tests compare against hand values.
module tb_accumulator_drain_scheduler;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 1024;

    logic              clk            = 1'b0;
    logic              rst_i          = 1'b1;
    logic              drain_start_i  = 1'b0;
    logic [ADDR_W-1:0] base_addr_i    = '0;
    logic [ADDR_W-1:0] row_cnt_i      = '0;
    logic [ADDR_W-1:0] ub_base_addr_i = '0;
    logic              mac_rd_req_i   = 1'b0;
    logic [ADDR_W-1:0] mac_rd_addr_i  = 10'h3FF;
    logic [DATA_W-1:0] accum_rd_data_i = '0;
    logic              ub_wr_ready_i  = 1'b1;
    logic              mac_rd_grant_o;
    logic              accum_rd_en_o;
    logic [ADDR_W-1:0] accum_rd_addr_o;
    logic              ub_wr_valid_o;
    logic [ADDR_W-1:0] ub_wr_addr_o;
    logic [DATA_W-1:0] ub_wr_data_o;
    logic              busy_o;
    logic              drain_done_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int busy_n   = 0;
    int n_rd     = 0;
    int n_wr     = 0;

    bit mac_mode   = 1'b0;
    bit mac_force  = 1'b1;
    bit ready_mode = 1'b0;
    bit occ_mode   = 1'b0;

    int          rd_cyc[$];
    logic [9:0]  rd_addr[$];
    int          gnt_cyc[$];
    logic [9:0]  gnt_addr[$];
    int          wr_cyc[$];
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_word[$];
    logic        wr_full[$];
    int          done_cyc[$];

    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [DATA_W-1:0] prev_data  = '0;

    accumulator_drain_scheduler dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .drain_start_i   (drain_start_i),
        .base_addr_i     (base_addr_i),
        .row_cnt_i       (row_cnt_i),
        .ub_base_addr_i  (ub_base_addr_i),
        .mac_rd_req_i    (mac_rd_req_i),
        .mac_rd_addr_i   (mac_rd_addr_i),
        .mac_rd_grant_o  (mac_rd_grant_o),
        .accum_rd_en_o   (accum_rd_en_o),
        .accum_rd_addr_o (accum_rd_addr_o),
        .accum_rd_data_i (accum_rd_data_i),
        .ub_wr_valid_o   (ub_wr_valid_o),
        .ub_wr_ready_i   (ub_wr_ready_i),
        .ub_wr_addr_o    (ub_wr_addr_o),
        .ub_wr_data_o    (ub_wr_data_o),
        .busy_o          (busy_o),
        .drain_done_o    (drain_done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [9:0] a, input logic mac);
        return {(mac ? 8'hEE : 8'hD0), 14'h0, a};
    endfunction

    function automatic logic ready_fn(input int r);
        case (r)
            3, 5:                 return 1'b1;
            4, 6, 7, 8, 9, 10, 11: return 1'b0;
            default:              return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Accumulator memory model: tagged data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (accum_rd_en_o) accum_rd_data_i <= {32{pat(accum_rd_addr_o, mac_rd_grant_o)}};
        else               accum_rd_data_i <= {32{32'hBAD0BAD0}};
    end

    always @(posedge clk) begin : drv
        int rel;
        #2;
        rel = cyc - t0;
        mac_rd_req_i  = mac_force || (mac_mode && (rel == 2 || rel == 3));
        ub_wr_ready_i = !ready_mode || ready_fn(rel);
    end

    always @(negedge clk) begin : mon
        int rel;
        rel = cyc - t0;
        if (accum_rd_en_o && !mac_rd_grant_o) begin
            rd_cyc.push_back(rel);
            rd_addr.push_back(accum_rd_addr_o);
            n_rd++;
        end
        if (mac_rd_grant_o) begin
            gnt_cyc.push_back(rel);
            gnt_addr.push_back(accum_rd_addr_o);
        end
        if (prev_stall) begin
            check("stall_valid", ub_wr_valid_o, 1);
            check("stall_addr", ub_wr_addr_o, prev_addr);
            check("stall_data", ub_wr_data_o == prev_data, 1);
        end
        if (ub_wr_valid_o && ub_wr_ready_i) begin
            wr_cyc.push_back(rel);
            wr_addr.push_back(ub_wr_addr_o);
            wr_word.push_back(ub_wr_data_o[31:0]);
            wr_full.push_back(ub_wr_data_o == {32{ub_wr_data_o[31:0]}});
            n_wr++;
        end
        if (occ_mode && (accum_rd_en_o || ub_wr_valid_o)) check("occupancy", (n_rd - n_wr) <= 2, 1);
        if (drain_done_o) done_cyc.push_back(rel);
        if (busy_o) busy_n++;
        prev_stall = ub_wr_valid_o && !ub_wr_ready_i && !rst_i;
        prev_addr  = ub_wr_addr_o;
        prev_data  = ub_wr_data_o;
    end

    task automatic start(input logic [9:0] b, input logic [9:0] n, input logic [9:0] u);
        @(posedge clk); #1;
        t0 = cyc;
        rd_cyc.delete(); rd_addr.delete(); gnt_cyc.delete(); gnt_addr.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_word.delete(); wr_full.delete(); done_cyc.delete();
        n_rd = 0; n_wr = 0; busy_n = 0;
        base_addr_i = b; row_cnt_i = n; ub_base_addr_i = u; drain_start_i = 1'b1;
        @(posedge clk); #1;
        drain_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", done_cyc.size() != 0, 1);
        repeat (3) @(posedge clk);
        check("done_count", done_cyc.size(), 1);
    endtask

    task automatic verify_stream(input string tag, input logic [9:0] base, input logic [9:0] ub,
                                 input int nrd, input int nwr);
        check({tag, "_nrd"}, rd_addr.size(), nrd);
        check({tag, "_nwr"}, wr_addr.size(), nwr);
        for (int i = 0; i < nrd; i++)
            if (i < rd_addr.size()) check({tag, "_rd_addr"}, rd_addr[i], 10'(base + i));
        for (int i = 0; i < nwr; i++) begin
            if (i < wr_addr.size()) begin
                check({tag, "_wr_addr"}, wr_addr[i], 10'(ub + i));
                check({tag, "_wr_data"}, wr_word[i], pat(10'(base + i), 1'b0));
                check({tag, "_wr_full"}, wr_full[i], 1);
            end
        end
    endtask

    task automatic verify_cycles(input string tag, input int rd0[$], input int wr0[$], input int dn);
        for (int i = 0; i < rd0.size(); i++)
            if (i < rd_cyc.size()) check({tag, "_rd_cyc"}, rd_cyc[i], rd0[i]);
        for (int i = 0; i < wr0.size(); i++)
            if (i < wr_cyc.size()) check({tag, "_wr_cyc"}, wr_cyc[i], wr0[i]);
        if (done_cyc.size() > 0) check({tag, "_done_cyc"}, done_cyc[0], dn);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: outputs forced low even with a MAC request pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", mac_rd_grant_o, 0);
        check("rst_rd_en", accum_rd_en_o, 0);
        check("rst_rd_addr", accum_rd_addr_o, 0);
        check("rst_ub_valid", ub_wr_valid_o, 0);
        check("rst_ub_addr", ub_wr_addr_o, 0);
        check("rst_ub_data", ub_wr_data_o == '0, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", drain_done_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rel_grant", mac_rd_grant_o, 1);
        check("rel_rd_en", accum_rd_en_o, 1);
        check("rel_rd_addr", accum_rd_addr_o, 10'h3FF);
        mac_force = 1'b0;
        repeat (3) @(posedge clk);

        // Basic drain, ready always high.
        start(10'h010, 10'd4, 10'h100);
        wait_done(30);
        verify_stream("t1", 10'h010, 10'h100, 4, 4);
        verify_cycles("t1", '{1, 2, 3, 4}, '{3, 4, 5, 6}, 7);
        check("t1_busy_cycles", busy_n, 7);

        // MAC requests in T+2..T+3 preempt the drain.
        mac_mode = 1'b1;
        start(10'h010, 10'd4, 10'h100);
        wait_done(30);
        mac_mode = 1'b0;
        verify_stream("t2", 10'h010, 10'h100, 4, 4);
        verify_cycles("t2", '{1, 4, 5, 6}, '{3, 6, 7, 8}, 9);
        check("t2_ngrant", gnt_cyc.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (i < gnt_cyc.size()) begin
                check("t2_grant_cyc", gnt_cyc[i], 2 + i);
                check("t2_grant_addr", gnt_addr[i], 10'h3FF);
            end
        end

        // Back-pressure pattern on the write stream.
        ready_mode = 1'b1;
        occ_mode   = 1'b1;
        start(10'h080, 10'd8, 10'h180);
        wait_done(80);
        ready_mode = 1'b0;
        occ_mode   = 1'b0;
        verify_stream("t3", 10'h080, 10'h180, 8, 8);

        // Zero rows.
        start(10'h050, 10'd0, 10'h150);
        wait_done(10);
        verify_stream("t4", 10'h050, 10'h150, 0, 0);
        verify_cycles("t4", '{}, '{}, 1);
        check("t4_busy_cycles", busy_n, 1);

        // Address wrap on both sides.
        start(10'h3FE, 10'd3, 10'h3FF);
        wait_done(30);
        verify_stream("t5", 10'h3FE, 10'h3FF, 3, 3);
        verify_cycles("t5", '{1, 2, 3}, '{3, 4, 5}, 6);

        // Mid-drain reset with an ignored restart while busy.
        start(10'h020, 10'd8, 10'h200);
        @(posedge clk); #1;
        base_addr_i = 10'h155; row_cnt_i = 10'd1; ub_base_addr_i = 10'h055;
        drain_start_i = 1'b1;
        @(posedge clk); #1;
        drain_start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i     = 1'b1;
        mac_force = 1'b1;
        @(negedge clk);
        check("t6_rst_grant", mac_rd_grant_o, 0);
        check("t6_rst_rd_en", accum_rd_en_o, 0);
        check("t6_rst_rd_addr", accum_rd_addr_o, 0);
        check("t6_rst_ub_valid", ub_wr_valid_o, 0);
        check("t6_rst_ub_addr", ub_wr_addr_o, 0);
        check("t6_rst_ub_data", ub_wr_data_o == '0, 1);
        check("t6_rst_busy", busy_o, 0);
        @(posedge clk); #1;
        rst_i     = 1'b0;
        mac_force = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t6_no_done", done_cyc.size(), 0);
        check("t6_busy_after", busy_o, 0);
        check("t6_valid_after", ub_wr_valid_o, 0);
        verify_stream("t6", 10'h020, 10'h200, 5, 3);

        // Fresh drain after the abandoned one.
        start(10'h030, 10'd2, 10'h040);
        wait_done(30);
        verify_stream("t7", 10'h030, 10'h040, 2, 2);
        verify_cycles("t7", '{1, 2}, '{3, 4}, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accumulator_drain_scheduler.md
ACCUMULATOR_DRAIN_SCHEDULER -- requirements
Module: accumulator_drain_scheduler

Interface
REQ-001 SHALL have parameters: MUL_SIZE, 32, systolic array width; ADDR_W, 10, accumulator/unified-buffer address width; DATA_W, 1024, accumulator row width in bits.
REQ-002 SHALL have ports: clk_i  in  1  clock, all state on rising edge; rst_i  in  1  reset; one clock, reset asynchronous and active-high.
REQ-003 SHALL have ports: drain_start_i  in  1  start pulse; base_addr_i  in  ADDR_W  first accumulator row; row_cnt_i  in  ADDR_W  rows to drain; ub_base_addr_i  in  ADDR_W  first unified-buffer row.
REQ-004 SHALL have ports: mac_rd_req_i  in  1  accumulate-path read request; mac_rd_addr_i  in  ADDR_W  its address; mac_rd_grant_o  out  1  request granted this cycle.
REQ-005 SHALL have ports: accum_rd_en_o  out  1  accumulator read strobe; accum_rd_addr_o  out  ADDR_W  read address; accum_rd_data_i  in  DATA_W  read data, valid exactly 1 cycle after strobe.
REQ-006 SHALL have ports: ub_wr_valid_o  out  1; ub_wr_ready_i  in  1; ub_wr_addr_o  out  ADDR_W; ub_wr_data_o  out  DATA_W  valid/ready write stream to unified buffer.
REQ-007 SHALL have ports: busy_o  out  1  state not IDLE; drain_done_o  out  1  one-cycle completion pulse.

Function
REQ-008 SHALL implement FSM IDLE, ISSUE, FLUSH, DONE.
REQ-009 IDLE: on drain_start_i SHALL latch base_addr_i, row_cnt_i, ub_base_addr_i, clear issue/write counters, go to ISSUE; if row_cnt_i == 0, go to DONE instead.
REQ-010 drain_start_i outside IDLE SHALL be ignored, latched values unchanged.
REQ-011 Read port arbitration SHALL be combinational, same cycle: mac_rd_req_i has absolute priority; mac_rd_grant_o = mac_rd_req_i in every state.
REQ-012 On MAC grant: accum_rd_en_o = 1, accum_rd_addr_o = mac_rd_addr_i; returning data SHALL NOT enter the drain buffer (1-bit tag pipeline marks drain vs MAC reads).
REQ-013 ISSUE: drain read issued in a cycle iff no mac_rd_req_i, issued count < latched row count, and (buffer occupancy + in-flight drain reads) < 2; address = base + issued count, modulo 2^ADDR_W.
REQ-014 Issued counter SHALL increment per drain read; ISSUE -> FLUSH on cycle last read is issued.
REQ-015 Drain read data SHALL be captured into a 2-entry FIFO the cycle it returns; no data lost or duplicated under any ready pattern.
REQ-016 ub_wr_valid_o = FIFO non-empty; ub_wr_data_o = FIFO head; ub_wr_addr_o = ub_base + written count, modulo 2^ADDR_W; all three stable while valid and not ready.
REQ-017 Transfer occurs when ub_wr_valid_o & ub_wr_ready_i; written count increments; simultaneous FIFO push and pop SHALL keep occupancy.
REQ-018 FLUSH -> DONE when written count == latched row count (FIFO empty, nothing in flight).
REQ-019 DONE: drain_done_o = 1 for exactly one cycle, then IDLE; drain_done_o is registered.
REQ-020 Latency: start in cycle T, no MAC requests, ready high -> first read in T+1, first ub_wr_valid_o in T+3, one row per cycle sustained thereafter.
REQ-021 Counters ADDR_W+1 bits wide; row_cnt_i up to 2^ADDR_W-1 supported.
REQ-022 busy_o = 1 in ISSUE, FLUSH, DONE; 0 in IDLE.

Reset
REQ-023 rst_i asserted SHALL immediately force IDLE, empty FIFO, clear tag pipe and counters; all outputs 0 (accum_rd_addr_o, ub_wr_addr_o, ub_wr_data_o = 0), mac_rd_grant_o still follows mac_rd_req_i only after reset release.
REQ-024 Reset mid-drain SHALL abandon the operation with no drain_done_o pulse; data returning after release SHALL be discarded.

Verification
REQ-025 base 0x010, rows 4, ub_base 0x100, ready high -> reads 0x010..0x013 in T+1..T+4, writes 0x100..0x103 with matching data in T+3..T+6, drain_done_o pulse T+7 (DONE state).
REQ-026 Same drain, mac_rd_req_i high cycles T+2..T+3 addr 0x3FF -> grant those cycles, reads to 0x3FF, drain reads stall, all 4 rows still written in order, MAC data never on ub_wr_data_o.
REQ-027 rows 8, ub_wr_ready_i toggling 1-0-1-0 and held low 5 cycles -> at most 2 in-flight+buffered, data/addr stable while stalled, 8 writes in order, no loss.
REQ-028 rows 0 -> no accum_rd_en_o, no ub_wr_valid_o, drain_done_o one cycle later, busy_o high one cycle.
REQ-029 base 0x3FE, rows 3 -> read addresses 0x3FE, 0x3FF, 0x000.
REQ-030 rst_i pulsed mid-drain (3 of 8 rows written), second drain_start_i while busy -> ignored; after reset all outputs 0, no done pulse, fresh drain completes normally.
